gate_note_stack: RTL and testbench
==================================

// Module: gate_note_stack
// PURPOSE
//  Keyboard-side producer of the GATE/GATEchgd envelope interface consumed by the ADSR envelope modules.
//  Accepts decoded note-on/note-off commands through a valid/ready handshake.
//  Holds the currently held notes in a last-note-priority stack.
//  Drives GATE, a one-cycle GATEchgd strobe, and the current NOTE/VEL to the voice (oscillator + envelopes).
// PARAMETERS
//  DEPTH          8  max held notes in the stack (2..16)
//  CNT_W          4  width of held_count; must hold DEPTH (clog2(DEPTH+1))
//  LEGATO_RETRIG  1  1: strobe GATEchgd when the sounding note changes while GATE stays high; 0: no strobe
// PORTS
//  clock       in   1      system clock (50 MHz)
//  reset       in   1      asynchronous, active-high reset
//  cmd_valid   in   1      command present
//  cmd_ready   out  1      block can accept a command
//  cmd_on      in   1      1 = note-on, 0 = note-off
//  cmd_note    in   7      MIDI note number
//  cmd_vel     in   7      velocity (note-on only; ignored for note-off)
//  all_off     in   1      flush all held notes (panic / all-notes-off)
//  GATE        out  1      high while at least one note is held
//  GATEchgd    out  1      one-cycle strobe: GATE edge or legato retrigger
//  NOTE        out  7      sounding note (top of stack)
//  VEL         out  7      velocity of sounding note
//  held_count  out  CNT_W  number of held notes
// BEHAVIOUR
//  Clock and reset:
//  - One clock domain (clock). reset is asynchronous, active-high.
//  - Reset values: stack empty, held_count=0, GATE=0, GATEchgd=0, NOTE=0, VEL=0, state IDLE, cmd_ready=1.
//  Stack:
//  - Entries {note,vel}; index 0 = oldest, index held_count-1 = top (sounding).
//  - Entries above held_count are don't-care.
//  States:
//  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch cmd_on/note/vel, set scan index 0, go to SCAN. cmd_ready=0 outside IDLE.
//  - SCAN: compare one entry per cycle against the latched note; record hit index.
//    Occupies max(held_count,1) cycles, then goes to COMMIT.
//  - COMMIT (1 cycle), then IDLE:
//    - note-off, hit: remove entry, shift higher entries down by one, count-1.
//    - note-off, miss: no change at all, no strobe.
//    - note-on, hit: remove entry, then push {note,vel} on top; count unchanged (VEL refreshed).
//    - note-on, miss, not full: push on top, count+1.
//    - note-on, miss, full: drop index 0, shift down, push on top; count stays DEPTH.
//  Registered outputs, updated at the COMMIT edge:
//  - Count 0 -> >0: GATE<=1, GATEchgd=1 for one cycle.
//  - Count >0 -> 0: GATE<=0, GATEchgd=1 for one cycle; NOTE/VEL hold their last value so the release keeps its pitch.
//  - Count stays >0 and top {note} or its entry changed (new note-on, or top removed): NOTE/VEL <= new top; GATEchgd=1 iff LEGATO_RETRIG.
//  - Removal of a non-top entry: outputs unchanged, no strobe.
//  - GATEchgd is never high two consecutive cycles; it is 0 in all other cycles.
//  Latency and throughput:
//  - Accept edge T -> outputs valid after edge T+max(count,1)+1.
//  - cmd_ready high again the cycle after COMMIT.
//  all_off:
//  - Takes priority in any state, including over a cmd_valid in the same cycle.
//  - Next edge: count<=0, state<=IDLE; any in-flight command is dropped.
//  - If GATE was 1: GATE<=0 with GATEchgd strobe. If GATE was 0: no strobe.
//  - While all_off is held, cmd_ready=0.
//  Reset mid-command: in-flight command is lost; all outputs take their reset values immediately.
// TESTING
//  1. Reset; note-on 60 vel 100 -> after 3 cycles GATE=1, GATEchgd 1-cycle pulse, NOTE=60, VEL=100, held_count=1.
//  2. Hold 60, note-on 64 (LEGATO_RETRIG=1) -> NOTE=64, GATE stays 1, one GATEchgd pulse.
//     Then note-off 64 -> NOTE=60, pulse. Repeat with LEGATO_RETRIG=0 -> no pulses.
//  3. Held 60,64,67; note-off 64 -> no output change, no pulse, held_count=2.
//     Note-off 50 (absent) -> nothing changes.
//  4. DEPTH=8: press 60..68 (9 notes) -> held_count=8, NOTE=68.
//     Release 68..61 in turn -> NOTE steps down to 61; release 61 -> GATE=0, pulse, NOTE stays 61 (60 was dropped).
//  5. Re-press top note 60 with vel 20 while held -> count unchanged, VEL=20, pulse iff LEGATO_RETRIG.
//  6. all_off asserted together with cmd_valid during SCAN of a 3-note stack -> count=0, GATE=0, single pulse, command discarded.
//     Async reset mid-SCAN -> GATE=0 immediately, cmd_ready=1.

Source files
------------

// File: rtl/gate_note_stack.sv
// Last-note-priority keyboard stack driving the GATE/GATEchgd envelope interface.
// Commands are scanned one stack entry per cycle, then committed in a single cycle.
module gate_note_stack #(
  parameter int DEPTH         = 8,
  parameter int CNT_W         = 4,
  parameter int LEGATO_RETRIG = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_on,
  input  logic [6:0]       cmd_note,
  input  logic [6:0]       cmd_vel,
  input  logic             all_off,
  output logic             GATE,
  output logic             GATEchgd,
  output logic [6:0]       NOTE,
  output logic [6:0]       VEL,
  output logic [CNT_W-1:0] held_count
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t           state_q, state_d;
  logic             accept;

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] scan_q, scan_d;
  logic [CNT_W-1:0] hit_idx_q, hit_idx_d;
  logic             hit_q, hit_d;
  logic [CNT_W-1:0] scan_span;
  logic             scan_last;
  logic             cur_hit;

  logic             on_q;
  logic [6:0]       lnote_q, lvel_q;

  logic [6:0]       snote_q [DEPTH];
  logic [6:0]       svel_q  [DEPTH];
  logic [6:0]       snote_d [DEPTH];
  logic [6:0]       svel_d  [DEPTH];

  logic             remove;
  logic [CNT_W-1:0] rm_idx;
  logic [CNT_W-1:0] cnt_rm;
  logic [CNT_W-1:0] cnt_new;
  logic             top_chg;
  logic [6:0]       top_note, top_vel;

  logic             gate_q, gate_d;
  logic             gchg_q, gchg_d;
  logic             pend_q, pend_d;
  logic             strobe_req;
  logic [6:0]       note_q, note_d;
  logic [6:0]       vel_q, vel_d;

  // FSM: state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state; all_off aborts whatever is in flight
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SCAN;
      SCAN:    if (scan_last) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (all_off) state_d = IDLE;
  end

  // FSM: outputs
  always_comb begin
    cmd_ready = (state_q == IDLE) && !all_off;
    accept    = cmd_ready && cmd_valid;
  end

  // An empty stack still spends one scan cycle
  always_comb begin
    scan_span = (count_q == '0) ? ONE : count_q;
    scan_last = (scan_q == scan_span - ONE);
    cur_hit   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) == scan_q && scan_q < count_q && snote_q[i] == lnote_q) cur_hit = 1'b1;
    end
  end

  always_comb begin
    scan_d    = scan_q;
    hit_d     = hit_q;
    hit_idx_d = hit_idx_q;
    if (accept) begin
      scan_d    = '0;
      hit_d     = 1'b0;
      hit_idx_d = '0;
    end else if (state_q == SCAN) begin
      scan_d = scan_q + ONE;
      if (cur_hit) begin
        hit_d     = 1'b1;
        hit_idx_d = scan_q;
      end
    end
  end

  // Commit: optional removal (hit, or oldest entry when full) followed by optional push
  always_comb begin
    remove  = hit_q || (on_q && count_q == FULL);
    rm_idx  = hit_q ? hit_idx_q : '0;
    cnt_rm  = remove ? count_q - ONE : count_q;
    cnt_new = on_q ? cnt_rm + ONE : cnt_rm;
    top_chg = on_q || (hit_q && hit_idx_q == count_q - ONE);
    for (int i = 0; i < DEPTH; i++) begin
      snote_d[i] = snote_q[i];
      svel_d[i]  = svel_q[i];
    end
    if (state_q == COMMIT) begin
      if (remove) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          if (CNT_W'(i) >= rm_idx) begin
            snote_d[i] = snote_q[i+1];
            svel_d[i]  = svel_q[i+1];
          end
        end
      end
      if (on_q) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i) == cnt_rm) begin
            snote_d[i] = lnote_q;
            svel_d[i]  = lvel_q;
          end
        end
      end
    end
    top_note = lnote_q;
    top_vel  = lvel_q;
    if (!on_q) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == cnt_new - ONE) begin
          top_note = snote_d[i];
          top_vel  = svel_d[i];
        end
      end
    end
  end

  // A strobe that would land right after another one is deferred a cycle
  always_comb begin
    count_d    = count_q;
    gate_d     = gate_q;
    note_d     = note_q;
    vel_d      = vel_q;
    strobe_req = 1'b0;
    if (all_off) begin
      count_d    = '0;
      gate_d     = 1'b0;
      strobe_req = gate_q;
    end else if (state_q == COMMIT) begin
      count_d = cnt_new;
      gate_d  = (cnt_new != '0);
      if (gate_d && top_chg) begin
        note_d = top_note;
        vel_d  = top_vel;
      end
      strobe_req = (gate_d != gate_q) ||
                   (gate_q && gate_d && top_chg && (LEGATO_RETRIG != 0));
    end
    gchg_d = (strobe_req || pend_q) && !gchg_q;
    pend_d = (strobe_req || pend_q) && gchg_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      scan_q    <= '0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
      gate_q    <= 1'b0;
      gchg_q    <= 1'b0;
      pend_q    <= 1'b0;
      note_q    <= '0;
      vel_q     <= '0;
    end else begin
      count_q   <= count_d;
      scan_q    <= scan_d;
      hit_q     <= hit_d;
      hit_idx_q <= hit_idx_d;
      gate_q    <= gate_d;
      gchg_q    <= gchg_d;
      pend_q    <= pend_d;
      note_q    <= note_d;
      vel_q     <= vel_d;
    end
  end

  // Stack contents and the latched command are pure data: no reset
  always_ff @(posedge clock) begin
    if (accept) begin
      on_q    <= cmd_on;
      lnote_q <= cmd_note;
      lvel_q  <= cmd_vel;
    end
    for (int i = 0; i < DEPTH; i++) begin
      snote_q[i] <= snote_d[i];
      svel_q[i]  <= svel_d[i];
    end
  end

  assign GATE       = gate_q;
  assign GATEchgd   = gchg_q;
  assign NOTE       = note_q;
  assign VEL        = vel_q;
  assign held_count = count_q;

endmodule

// File: tb/tb_gate_note_stack.sv
// Bench for gate_note_stack: two instances (legato retrigger on/off) share stimulus and
// are compared against a queue-based model of the held-note stack.
module tb_gate_note_stack;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_on, all_off;
  logic [6:0] cmd_note, cmd_vel;

  logic             rdy1, g1, gc1, rdy0, g0, gc0;
  logic [6:0]       n1, v1, n0, v0;
  logic [CNT_W-1:0] hc1, hc0;

  int n_assert = 0;
  int n_fail   = 0;

  int mn[$];
  int mv[$];
  int m_note = 0;
  int m_vel  = 0;

  always #10 clock = ~clock;

  gate_note_stack #(.DEPTH(DEPTH), .CNT_W(CNT_W), .LEGATO_RETRIG(1)) dut1 (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
    .cmd_on(cmd_on), .cmd_note(cmd_note), .cmd_vel(cmd_vel), .all_off(all_off),
    .GATE(g1), .GATEchgd(gc1), .NOTE(n1), .VEL(v1), .held_count(hc1));

  gate_note_stack #(.DEPTH(DEPTH), .CNT_W(CNT_W), .LEGATO_RETRIG(0)) dut0 (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy0),
    .cmd_on(cmd_on), .cmd_note(cmd_note), .cmd_vel(cmd_vel), .all_off(all_off),
    .GATE(g0), .GATEchgd(gc0), .NOTE(n0), .VEL(v0), .held_count(hc0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int s1, input int s0);
    int eg;
    eg = (mn.size() > 0) ? 1 : 0;
    chk({tag, " gate1"}, 32'(g1), eg);
    chk({tag, " gate0"}, 32'(g0), eg);
    chk({tag, " chgd1"}, 32'(gc1), s1);
    chk({tag, " chgd0"}, 32'(gc0), s0);
    chk({tag, " note1"}, 32'(n1), m_note);
    chk({tag, " note0"}, 32'(n0), m_note);
    chk({tag, " vel1"},  32'(v1), m_vel);
    chk({tag, " vel0"},  32'(v0), m_vel);
    chk({tag, " cnt1"},  32'(hc1), mn.size());
    chk({tag, " cnt0"},  32'(hc0), mn.size());
  endtask

  // Reference: apply one command to the held-note list and derive the expected strobes
  task automatic model_cmd(input bit on, input int note, input int vel, output int s1, output int s0);
    int idx;
    int c;
    bit tc;
    idx = -1;
    c   = mn.size();
    tc  = 1'b0;
    foreach (mn[i]) if (mn[i] == note) idx = i;
    if (on) begin
      if (idx >= 0) begin
        mn.delete(idx); mv.delete(idx);
      end else if (c == DEPTH) begin
        mn.delete(0); mv.delete(0);
      end
      mn.push_back(note); mv.push_back(vel);
      tc = 1'b1;
    end else if (idx >= 0) begin
      tc = (idx == c - 1);
      mn.delete(idx); mv.delete(idx);
    end
    if (mn.size() > 0 && tc) begin
      m_note = mn[$];
      m_vel  = mv[$];
    end
    if ((c == 0) != (mn.size() == 0)) begin
      s1 = 1; s0 = 1;
    end else if (c > 0 && mn.size() > 0 && tc) begin
      s1 = 1; s0 = 0;
    end else begin
      s1 = 0; s0 = 0;
    end
  endtask

  // Called at a negedge with the block idle; returns at a negedge with the block idle
  task automatic send(input string tag, input bit on, input int note, input int vel);
    int s1, s0, n, oldc;
    chk({tag, " ready1"}, 32'(rdy1), 1);
    chk({tag, " ready0"}, 32'(rdy0), 1);
    cmd_valid = 1'b1; cmd_on = on; cmd_note = 7'(note); cmd_vel = 7'(vel);
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0; cmd_note = 7'($urandom_range(0, 127)); cmd_vel = 7'($urandom_range(0, 127));
    oldc = mn.size();
    n = (oldc == 0) ? 1 : oldc;
    for (int k = 0; k <= n; k++) begin
      chk({tag, " busy"},     32'(rdy1), 0);
      chk({tag, " nochg"},    32'(gc1 | gc0), 0);
      chk({tag, " holdcnt"},  32'(hc1), oldc);
      @(negedge clock);
    end
    model_cmd(on, note, vel, s1, s0);
    check_outs(tag, s1, s0);
    chk({tag, " ready_back"}, 32'(rdy1), 1);
    @(negedge clock);
    chk({tag, " pulse_end1"}, 32'(gc1), 0);
    chk({tag, " pulse_end0"}, 32'(gc0), 0);
  endtask

  task automatic do_all_off(input string tag);
    int s;
    s = (mn.size() > 0) ? 1 : 0;
    all_off = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk({tag, " ready_held"}, 32'(rdy1), 0);
    all_off = 1'b0;
    mn.delete(); mv.delete();
    #1;
    check_outs(tag, s, s);
    chk({tag, " ready_rel"}, 32'(rdy1), 1);
    @(negedge clock);
    chk({tag, " pulse_end"}, 32'(gc1 | gc0), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_on = 1'b0; all_off = 1'b0;
    cmd_note = '0; cmd_vel = '0;
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_outs("reset", 0, 0);
    chk("reset ready", 32'(rdy1), 1);

    send("on60", 1, 60, 100);
    send("on64", 1, 64, 90);
    send("off64", 0, 64, 0);
    send("on64b", 1, 64, 80);
    send("on67", 1, 67, 70);
    send("off64mid", 0, 64, 0);
    send("off50miss", 0, 50, 0);
    send("off67top", 0, 67, 0);
    send("repress60", 1, 60, 20);
    do_all_off("alloff_idle");

    for (int k = 60; k <= 68; k++) send("fill", 1, k, k + 10);
    chk("full count", 32'(hc1), DEPTH);
    for (int k = 68; k >= 61; k--) send("release", 0, k, 0);
    chk("released note", 32'(n1), 61);
    send("off60dropped", 0, 60, 0);

    // all_off together with cmd_valid while a 3-note stack is being scanned
    send("s1", 1, 40, 11);
    send("s2", 1, 41, 12);
    send("s3", 1, 42, 13);
    cmd_valid = 1'b1; cmd_on = 1'b0; cmd_note = 7'd42;
    @(posedge clock);
    @(negedge clock);
    cmd_on = 1'b1; cmd_note = 7'd99; cmd_vel = 7'd99;
    all_off = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("abort ready_held", 32'(rdy1), 0);
    all_off = 1'b0; cmd_valid = 1'b0;
    mn.delete(); mv.delete();
    #1;
    check_outs("abort", 1, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check_outs("abort_quiet", 0, 0);
    end

    // asynchronous reset during a scan
    send("r1", 1, 70, 50);
    send("r2", 1, 72, 51);
    cmd_valid = 1'b1; cmd_on = 1'b1; cmd_note = 7'd74; cmd_vel = 7'd52;
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    reset = 1'b1;
    #1;
    mn.delete(); mv.delete(); m_note = 0; m_vel = 0;
    check_outs("async_rst", 0, 0);
    chk("async_rst ready", 32'(rdy1), 1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 99) < 4) do_all_off("rnd_alloff");
      else send("rnd", ($urandom_range(0, 99) < 60), $urandom_range(55, 66), $urandom_range(1, 127));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
